// File: rtl/row_min_tracker.sv
// Serial min/sub-min tracker for one LDPC check-node row: takes DEG magnitude/sign
// pairs over valid/ready and presents min, second min, min position and sign product.
module row_min_tracker #(
  parameter int WIDTH = 7,
  parameter int DEG   = 24,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min_v,
  output logic [WIDTH-1:0] submin_v,
  output logic [IDX_W-1:0] min_idx,
  output logic             sign_prod
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             last;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == IDX_W'(DEG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && last) state_nxt = HOLD;
      HOLD:    if (out_ready)      state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Accumulation: first element seeds the row; ties keep the earliest position
  // and push the equal magnitude into the sub-min slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      min_v     <= '0;
      submin_v  <= '0;
      min_idx   <= '0;
      sign_prod <= 1'b0;
    end else if (accept) begin
      if (cnt == '0) begin
        min_v     <= in_mag;
        submin_v  <= '1;
        min_idx   <= '0;
        sign_prod <= in_sign;
      end else begin
        if (in_mag < min_v) begin
          submin_v <= min_v;
          min_v    <= in_mag;
          min_idx  <= cnt;
        end else if (in_mag < submin_v) begin
          submin_v <= in_mag;
        end
        sign_prod <= sign_prod ^ in_sign;
      end
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_row_min_tracker.sv
// Directed and randomized-gap checks of row_min_tracker at DEG=24 and DEG=2.
module tb_row_min_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [6:0] in_mag;
  logic       in_sign;
  logic       in_ready, out_valid;
  logic [6:0] min_v, submin_v;
  logic [4:0] min_idx;
  logic       sign_prod;

  logic       in_valid2, out_ready2;
  logic [6:0] in_mag2;
  logic       in_sign2;
  logic       in_ready2, out_valid2;
  logic [6:0] min_v2, submin_v2;
  logic [0:0] min_idx2;
  logic       sign_prod2;

  int n_checks = 0;
  int n_fails  = 0;

  logic [6:0] row_mag [24];
  logic       row_sign[24];
  int exp_min, exp_sub, exp_idx, exp_sp;

  always #5 clk = ~clk;

  row_min_tracker #(.WIDTH(7), .DEG(24), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready),
    .min_v(min_v), .submin_v(submin_v), .min_idx(min_idx), .sign_prod(sign_prod)
  );

  row_min_tracker #(.WIDTH(7), .DEG(2), .IDX_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_mag(in_mag2), .in_sign(in_sign2), .out_valid(out_valid2), .out_ready(out_ready2),
    .min_v(min_v2), .submin_v(submin_v2), .min_idx(min_idx2), .sign_prod(sign_prod2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_min"}, min_v, exp_min);
    chk({tag, "_sub"}, submin_v, exp_sub);
    chk({tag, "_idx"}, min_idx, exp_idx);
    chk({tag, "_sp"},  sign_prod, exp_sp);
  endtask

  // Independent reference: min is the smallest value at its first position,
  // sub-min is the smallest of all other positions.
  task automatic model_row();
    exp_min = 1000; exp_idx = 0; exp_sp = 0; exp_sub = 1000;
    for (int i = 0; i < 24; i++) begin
      if (int'(row_mag[i]) < exp_min) begin exp_min = row_mag[i]; exp_idx = i; end
      exp_sp ^= int'(row_sign[i]);
    end
    for (int i = 0; i < 24; i++)
      if (i != exp_idx && int'(row_mag[i]) < exp_sub) exp_sub = row_mag[i];
  endtask

  task automatic send_row(input string tag, input int gap_pct, input int n);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_mag   = 7'($urandom_range(127));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_mag   = row_mag[i];
      in_sign  = row_sign[i];
      chk({tag, "_rdy"}, in_ready, 1);
      @(posedge clk); #1;
      if (i < 23) chk({tag, "_ov_early"}, out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int hold_cycles);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_ir_hold"}, in_ready, 0);
    chk_fields(tag);
    out_ready = 1'b0;
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid = 1'b1;
      in_mag   = 7'd0;
      in_sign  = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ov_bp"}, out_valid, 1);
      chk({tag, "_ir_bp"}, in_ready, 0);
      chk_fields({tag, "_bp"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_done"}, out_valid, 0);
    chk({tag, "_ir_done"}, in_ready, 1);
  endtask

  task automatic send2(input int a, input int b, input int sa, input int sb,
                       input int emin, input int esub, input int eidx, input int esp);
    in_valid2 = 1'b1; in_mag2 = 7'(a); in_sign2 = 1'(sa);
    @(posedge clk); #1;
    chk("d2_ov_first", out_valid2, 0);
    in_mag2 = 7'(b); in_sign2 = 1'(sb);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("d2_ov", out_valid2, 1);
    chk("d2_ir", in_ready2, 0);
    chk("d2_min", min_v2, emin);
    chk("d2_sub", submin_v2, esub);
    chk("d2_idx", min_idx2, eidx);
    chk("d2_sp", sign_prod2, esp);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    chk("d2_ov_done", out_valid2, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mag = '0; in_sign = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_mag2 = '0; in_sign2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_min", min_v, 0);
    chk("rst_sub", submin_v, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Descending row, back to back
    for (int i = 0; i < 24; i++) begin row_mag[i] = 7'(24 - i); row_sign[i] = 1'b0; end
    send_row("desc", 0, 24);
    exp_min = 1; exp_sub = 2; exp_idx = 23; exp_sp = 0;
    drain("desc", 0);

    // Tie with the minimum, five negative signs
    for (int i = 0; i < 24; i++) begin row_mag[i] = 7'd100; row_sign[i] = (i % 4 == 0) && (i < 20); end
    row_mag[0] = 7'd9; row_mag[1] = 7'd3; row_mag[2] = 7'd7; row_mag[3] = 7'd3;
    send_row("tie", 0, 24);
    exp_min = 3; exp_sub = 3; exp_idx = 1; exp_sp = 1;
    drain("tie", 0);

    // All-max row with 10 cycles of backpressure and ignored input
    for (int i = 0; i < 24; i++) begin row_mag[i] = 7'd127; row_sign[i] = 1'b0; end
    send_row("max", 30, 24);
    exp_min = 127; exp_sub = 127; exp_idx = 0; exp_sp = 0;
    drain("max", 10);

    // Abort a row after 10 elements with reset
    for (int i = 0; i < 24; i++) begin row_mag[i] = 7'd1; row_sign[i] = 1'b1; end
    send_row("abort", 0, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_min_in_rst", min_v, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ov", out_valid, 0);
    chk("abort_ir", in_ready, 1);
    chk("abort_min", min_v, 0);
    chk("abort_sub", submin_v, 0);
    chk("abort_idx", min_idx, 0);
    chk("abort_sp", sign_prod, 0);
    for (int i = 0; i < 24; i++) begin row_mag[i] = 7'd60; row_sign[i] = (i == 3); end
    row_mag[5] = 7'd10; row_mag[17] = 7'd20;
    send_row("post", 0, 24);
    exp_min = 10; exp_sub = 20; exp_idx = 5; exp_sp = 1;
    drain("post", 0);

    // DEG=2 instance
    send2(5, 4, 0, 1, 4, 5, 1, 1);
    send2(4, 5, 1, 1, 4, 5, 0, 0);
    send2(6, 6, 0, 0, 6, 6, 0, 0);

    // Random rows with upstream gaps and random backpressure
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 24; i++) begin
        row_mag[i]  = 7'($urandom_range(r % 2 ? 127 : 7));
        row_sign[i] = 1'($urandom_range(1));
      end
      model_row();
      send_row("rnd", 50, 24);
      drain("rnd", int'($urandom_range(3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
